// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: decode/EX/MEM hazard inputs and the
// stage enables, flushes, forwarding selects and memory status returned.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ewreg;
  logic        em2reg;
  logic [4:0]  eGPR;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [4:0]  mGPR;
  logic        ex_br_taken;
  logic        dmem_ack;
  logic        pc_en;
  logic        fd_en;
  logic        de_en;
  logic        em_en;
  logic        fd_flush;
  logic        de_flush;
  logic        mw_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        dmem_req;
  logic        mem_err;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ewreg, em2reg, eGPR,
           mwreg, mm2reg, mwmem, mGPR, ex_br_taken, dmem_ack,
    input  pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_bubble,
           fwd_a, fwd_b, dmem_req, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ewreg, em2reg, eGPR,
           mwreg, mm2reg, mwmem, mGPR, ex_br_taken, dmem_ack,
    output pc_en, fd_en, de_en, em_en, fd_flush, de_flush, mw_bubble,
           fwd_a, fwd_b, dmem_req, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, branch flush
// and data-memory wait freeze with timeout. HAZARD_STALL_CNT_EN enables stall_cnt.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] wait_cnt_r;
  logic       mem_err_r;

  logic       mem_access_s;
  logic       freeze_s;
  logic       load_use_s;
  logic       timeout_s;
  logic       pc_en_s;
  logic       fd_en_s;
  logic       de_en_s;
  logic       em_en_s;
  logic       fd_flush_s;
  logic       de_flush_s;
  logic       mw_bubble_s;
  logic       dmem_req_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // EX ALU results win over MEM; an EX load cannot forward and falls through to MEM
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ewreg,
    input logic       em2reg,
    input logic [4:0] egpr,
    input logic       mwreg,
    input logic       mm2reg,
    input logic [4:0] mgpr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ewreg && (egpr != 5'd0) && (egpr == src) && !em2reg) begin
      sel = 2'b01;
    end else if (mwreg && (mgpr != 5'd0) && (mgpr == src)) begin
      sel = mm2reg ? 2'b11 : 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign mem_access_s = hz.mm2reg | hz.mwmem;
  assign load_use_s   = hz.ewreg & hz.em2reg & (hz.eGPR != 5'd0) &
                        ((hz.id_use_rs & (hz.eGPR == hz.id_rs)) |
                         (hz.id_use_rt & (hz.eGPR == hz.id_rt)));
  // the 15th consecutive unacknowledged wait cycle gives up on the access
  assign timeout_s    = (state_r == MWAIT) && !hz.dmem_ack && (wait_cnt_r == 4'd14);

  // Next-state decode and freeze detection
  always_comb begin
    state_nxt_s = state_r;
    freeze_s    = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_access_s && !hz.dmem_ack) begin
          state_nxt_s = MWAIT;
          freeze_s    = 1'b1;
        end else begin
          state_nxt_s = RUN;
          freeze_s    = 1'b0;
        end
      end
      MWAIT: begin
        if (hz.dmem_ack || timeout_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = MWAIT;
        end
        freeze_s = !hz.dmem_ack;
      end
      default: begin
        state_nxt_s = RUN;
        freeze_s    = 1'b0;
      end
    endcase
  end

  // Stage control outputs in priority order: reset, freeze, branch, load-use
  always_comb begin
    pc_en_s     = 1'b1;
    fd_en_s     = 1'b1;
    de_en_s     = 1'b1;
    em_en_s     = 1'b1;
    fd_flush_s  = 1'b0;
    de_flush_s  = 1'b0;
    mw_bubble_s = 1'b0;
    dmem_req_s  = mem_access_s;
    fwd_a_s     = fwd_sel(hz.id_rs, hz.ewreg, hz.em2reg, hz.eGPR,
                          hz.mwreg, hz.mm2reg, hz.mGPR);
    fwd_b_s     = fwd_sel(hz.id_rt, hz.ewreg, hz.em2reg, hz.eGPR,
                          hz.mwreg, hz.mm2reg, hz.mGPR);
    if (!rst) begin
      pc_en_s    = 1'b0;
      fd_en_s    = 1'b0;
      de_en_s    = 1'b0;
      em_en_s    = 1'b0;
      dmem_req_s = 1'b0;
      fwd_a_s    = 2'b00;
      fwd_b_s    = 2'b00;
    end else if (freeze_s) begin
      pc_en_s     = 1'b0;
      fd_en_s     = 1'b0;
      de_en_s     = 1'b0;
      em_en_s     = 1'b0;
      mw_bubble_s = 1'b1;
    end else if (hz.ex_br_taken) begin
      fd_flush_s = 1'b1;
      de_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s    = 1'b0;
      fd_en_s    = 1'b0;
      de_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= 4'd0;
      mem_err_r  <= 1'b0;
    end else begin
      if ((state_r == RUN) && (state_nxt_s == MWAIT)) begin
        wait_cnt_r <= 4'd0;
      end else if ((state_r == MWAIT) && !hz.dmem_ack && (wait_cnt_r != 4'd15)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Count every cycle the PC is held while out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (!pc_en_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
`else
  assign hz.stall_cnt = 32'd0;
`endif

  assign hz.pc_en     = pc_en_s;
  assign hz.fd_en     = fd_en_s;
  assign hz.de_en     = de_en_s;
  assign hz.em_en     = em_en_s;
  assign hz.fd_flush  = fd_flush_s;
  assign hz.de_flush  = de_flush_s;
  assign hz.mw_bubble = mw_bubble_s;
  assign hz.fwd_a     = fwd_a_s;
  assign hz.fwd_b     = fwd_b_s;
  assign hz.dmem_req  = dmem_req_s;
  assign hz.mem_err   = mem_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; ctrl packs
// {pc_en,fd_en,de_en,em_en,fd_flush,de_flush,mw_bubble}.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [6:0] ctrl;

  hazard_ctrl_if hif ();

  hazard_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  assign ctrl = {hif.pc_en, hif.fd_en, hif.de_en, hif.em_en,
                 hif.fd_flush, hif.de_flush, hif.mw_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] C_RUN    = 7'b1111000;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_LDUSE  = 7'b0011010;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_RESET  = 7'b0000000;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hif.id_rs = 5'd0;  hif.id_rt = 5'd0;
    hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
    hif.ewreg = 1'b0; hif.em2reg = 1'b0; hif.eGPR = 5'd0;
    hif.mwreg = 1'b0; hif.mm2reg = 1'b0; hif.mwmem = 1'b0; hif.mGPR = 5'd0;
    hif.ex_br_taken = 1'b0; hif.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    hif.ewreg = 1'b1; hif.eGPR = 5'd4; hif.id_rs = 5'd4; hif.mm2reg = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RESET) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RESET); end
    n_cmp++; if (hif.fwd_a !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a: got %b want 00", hif.fwd_a); end
    n_cmp++; if (hif.dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_dmem_req: got %b want 0", hif.dmem_req); end
    n_cmp++; if (hif.mem_err !== 1'b0) begin n_err++; $display("FAIL reset_mem_err: got %b want 0", hif.mem_err); end
    n_cmp++; if (hif.stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", hif.stall_cnt); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL idle_ctrl: got %b want %b", ctrl, C_RUN); end
  endtask

  task automatic test_forward();
    clear_inputs();
    hif.ewreg = 1'b1; hif.eGPR = 5'd3; hif.id_rt = 5'd3; hif.id_use_rt = 1'b1; hif.id_rs = 5'd1;
    #1;
    n_cmp++; if (hif.fwd_b !== 2'b01) begin n_err++; $display("FAIL fwd_b_ex: got %b want 01", hif.fwd_b); end
    n_cmp++; if (hif.fwd_a !== 2'b00) begin n_err++; $display("FAIL fwd_a_nomatch: got %b want 00", hif.fwd_a); end
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL fwd_nostall: got %b want %b", ctrl, C_RUN); end
    hif.eGPR = 5'd0; hif.id_rt = 5'd0;
    #1;
    n_cmp++; if (hif.fwd_b !== 2'b00) begin n_err++; $display("FAIL fwd_b_r0: got %b want 00", hif.fwd_b); end
    clear_inputs();
    hif.mwreg = 1'b1; hif.mGPR = 5'd7; hif.id_rs = 5'd7;
    #1;
    n_cmp++; if (hif.fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_a_mem_alu: got %b want 10", hif.fwd_a); end
    hif.ewreg = 1'b1; hif.eGPR = 5'd7;
    #1;
    n_cmp++; if (hif.fwd_a !== 2'b01) begin n_err++; $display("FAIL fwd_a_ex_priority: got %b want 01", hif.fwd_a); end
    hif.em2reg = 1'b1;
    #1;
    n_cmp++; if (hif.fwd_a !== 2'b10) begin n_err++; $display("FAIL fwd_a_ex_load_skip: got %b want 10", hif.fwd_a); end
    clear_inputs();
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mGPR = 5'd9; hif.id_rt = 5'd9; hif.dmem_ack = 1'b1;
    #1;
    n_cmp++; if (hif.fwd_b !== 2'b11) begin n_err++; $display("FAIL fwd_b_mem_load: got %b want 11", hif.fwd_b); end
    step();
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hif.ewreg = 1'b1; hif.em2reg = 1'b1; hif.eGPR = 5'd5; hif.id_rs = 5'd5;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL lu_unused_src: got %b want %b", ctrl, C_RUN); end
    hif.id_use_rs = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_LDUSE) begin n_err++; $display("FAIL lu_stall: got %b want %b", ctrl, C_LDUSE); end
    step();
    hif.ewreg = 1'b0; hif.em2reg = 1'b0; hif.eGPR = 5'd0;
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mGPR = 5'd5; hif.dmem_ack = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL lu_release: got %b want %b", ctrl, C_RUN); end
    n_cmp++; if (hif.fwd_a !== 2'b11) begin n_err++; $display("FAIL lu_fwd_a: got %b want 11", hif.fwd_a); end
    step();
    clear_inputs();
    hif.ewreg = 1'b1; hif.em2reg = 1'b1; hif.eGPR = 5'd0; hif.id_rt = 5'd0; hif.id_use_rt = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL lu_r0: got %b want %b", ctrl, C_RUN); end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    hif.ex_br_taken = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL br_only: got %b want %b", ctrl, C_BRANCH); end
    hif.ewreg = 1'b1; hif.em2reg = 1'b1; hif.eGPR = 5'd6; hif.id_rt = 5'd6; hif.id_use_rt = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL br_over_lu: got %b want %b", ctrl, C_BRANCH); end
    step();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    hif.mwreg = 1'b1; hif.mm2reg = 1'b1; hif.mGPR = 5'd2;
    #1;
    n_cmp++; if (hif.dmem_req !== 1'b1) begin n_err++; $display("FAIL mw_req: got %b want 1", hif.dmem_req); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ctrl !== C_FREEZE) begin n_err++; $display("FAIL mw_freeze%0d: got %b want %b", i, ctrl, C_FREEZE); end
      step();
    end
    hif.dmem_ack = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL mw_advance: got %b want %b", ctrl, C_RUN); end
    step();
    clear_inputs();
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL mw_back_run: got %b want %b", ctrl, C_RUN); end
`ifdef HAZARD_STALL_CNT_EN
    n_cmp++; if (hif.stall_cnt !== 32'd3) begin n_err++; $display("FAIL mw_stall_cnt: got %0d want 3", hif.stall_cnt); end
`else
    n_cmp++; if (hif.stall_cnt !== 32'd0) begin n_err++; $display("FAIL mw_stall_cnt: got %0d want 0", hif.stall_cnt); end
`endif
  endtask

  task automatic test_branch_during_freeze();
    clear_inputs();
    hif.mwmem = 1'b1; hif.ex_br_taken = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_FREEZE) begin n_err++; $display("FAIL bf_freeze: got %b want %b", ctrl, C_FREEZE); end
    step();
    hif.mwmem = 1'b0;
    #1;
    n_cmp++; if (ctrl !== C_FREEZE) begin n_err++; $display("FAIL bf_wait_noreq: got %b want %b", ctrl, C_FREEZE); end
    hif.dmem_ack = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL bf_release: got %b want %b", ctrl, C_BRANCH); end
    step();
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    hif.mm2reg = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (hif.mem_err !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", hif.mem_err); end
    n_cmp++; if (ctrl !== C_FREEZE) begin n_err++; $display("FAIL to_last_freeze: got %b want %b", ctrl, C_FREEZE); end
    step();
    n_cmp++; if (hif.mem_err !== 1'b1) begin n_err++; $display("FAIL to_set: got %b want 1", hif.mem_err); end
    hif.mm2reg = 1'b0;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL to_forced_run: got %b want %b", ctrl, C_RUN); end
    hif.mm2reg = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (hif.mem_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", hif.mem_err); end
    rst = 1'b0;
    #1;
    n_cmp++; if (hif.mem_err !== 1'b0) begin n_err++; $display("FAIL to_rst_clear: got %b want 0", hif.mem_err); end
    n_cmp++; if (ctrl !== C_RESET || hif.dmem_req !== 1'b0) begin n_err++; $display("FAIL to_rst_ctrl: got %b/%b want %b/0", ctrl, hif.dmem_req, C_RESET); end
    hif.mm2reg = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ctrl !== C_RUN) begin n_err++; $display("FAIL to_abandon: got %b want %b", ctrl, C_RUN); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_freeze();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
